// File: rtl/risc_core_if.sv
// Memory-side bus of risc_core: the core (master) raises mem_rd or mem_wr with an address;
// the memory (slave) completes the access in the cycle it drives mem_ready high.
interface risc_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/risc_core.sv
// Single-clock accumulator CPU: FETCH/DECODE/OPREAD/OPWRITE/HALT over a rd/wr + mem_ready bus.
// Define RISC_CORE_PERF_EN to add the saturating retired-instruction counter port instr_count.
module risc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_,
  risc_core_if.master       mem,
  output logic              halt,
  output logic              load_ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] accum
`ifdef RISC_CORE_PERF_EN
  ,
  output logic [CNT_W-1:0]  instr_count
`endif
);

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_OPREAD  = 3'd2;
  localparam logic [2:0] ST_OPWRITE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] accum_q, accum_d;
  // Only the opcode and address fields of the instruction word are ever used.
  opcode_t           ir_op_q, ir_op_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;

  logic              rd_req;
  logic              wr_req;
  logic              ld_ir;
  logic [ADDR_W-1:0] addr_sel;
  logic              zero;

  assign zero = (accum_q == '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    accum_d   = accum_q;
    ir_op_d   = ir_op_q;
    ir_addr_d = ir_addr_q;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    ld_ir     = 1'b0;
    addr_sel  = pc_q;

    case (state_q)
      ST_FETCH: begin
        rd_req   = 1'b1;
        addr_sel = pc_q;
        if (mem.mem_ready) begin
          ir_op_d   = opcode_t'(mem.mem_rdata[DATA_W-1 -: 3]);
          ir_addr_d = mem.mem_rdata[ADDR_W-1:0];
          ld_ir     = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (ir_op_q)
          OP_HLT: state_d = ST_HALT;
          OP_SKZ: begin
            if (zero) begin
              pc_d = pc_q + ADDR_W'(1);
            end
            state_d = ST_FETCH;
          end
          OP_JMP: begin
            pc_d    = ir_addr_q;
            state_d = ST_FETCH;
          end
          OP_STO:  state_d = ST_OPWRITE;
          default: state_d = ST_OPREAD;
        endcase
      end

      ST_OPREAD: begin
        rd_req   = 1'b1;
        addr_sel = ir_addr_q;
        if (mem.mem_ready) begin
          case (ir_op_q)
            OP_ADD:  accum_d = accum_q + mem.mem_rdata;
            OP_AND:  accum_d = accum_q & mem.mem_rdata;
            OP_XOR:  accum_d = accum_q ^ mem.mem_rdata;
            default: accum_d = mem.mem_rdata;
          endcase
          state_d = ST_FETCH;
        end
      end

      ST_OPWRITE: begin
        wr_req   = 1'b1;
        addr_sel = ir_addr_q;
        if (mem.mem_ready) begin
          state_d = ST_FETCH;
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      accum_q   <= '0;
      ir_op_q   <= OP_HLT;
      ir_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      accum_q   <= accum_d;
      ir_op_q   <= ir_op_d;
      ir_addr_q <= ir_addr_d;
    end
  end

  // Requests are gated by rst_ so an in-flight access vanishes the moment reset asserts.
  assign mem.mem_addr  = addr_sel;
  assign mem.mem_rd    = rd_req & rst_;
  assign mem.mem_wr    = wr_req & rst_;
  assign mem.mem_wdata = accum_q;

  assign load_ir = ld_ir & rst_;
  assign halt    = (state_q == ST_HALT);
  assign pc      = pc_q;
  assign accum   = accum_q;

`ifdef RISC_CORE_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_DECODE) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_risc_core.sv
// Directed bench for risc_core: table of short ALU/STO programs plus hand-written
// sequences for reset mid-transaction, SKZ/JMP, PC wrap, wait states and the counter.
module tb_risc_core;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          halt;
  logic          load_ir;
  logic [AW-1:0] pc;
  logic [DW-1:0] accum;
`ifdef RISC_CORE_PERF_EN
  logic [1:0]    instr_count;
`endif

  risc_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  risc_core #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .mem         (bus),
    .halt        (halt),
    .load_ir     (load_ir),
    .pc          (pc),
    .accum       (accum)
`ifdef RISC_CORE_PERF_EN
    ,
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: img is the program image copied in while load_req is high.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] img [32];
  logic          load_req = 1'b0;
  logic          ready_in = 1'b1;
  logic [AW-1:0] wait_addr = '0;
  int            wait_n = 0;
  int            waited = 0;
  logic          overlap_seen = 1'b0;
  logic [AW-1:0] fetch_log[$];

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = ready_in;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] = img[i];
    end else if (rst_ && bus.mem_wr && bus.mem_ready) begin
      mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (!rst_) fetch_log.delete();
    else if (load_ir) fetch_log.push_back(bus.mem_addr);
  end

  // Wait-state injector: holds mem_ready low for wait_n cycles on requests to wait_addr.
  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_wr) overlap_seen = 1'b1;
    if (!rst_) begin
      waited   = 0;
      ready_in = 1'b1;
    end else if ((bus.mem_rd || bus.mem_wr) && bus.mem_addr == wait_addr && waited < wait_n) begin
      ready_in = 1'b0;
      waited   = waited + 1;
    end else begin
      ready_in = 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_     = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int edges);
    edges = -1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (halt) begin
        edges = e;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic [7:0] exp_m1f;
  } vec_t;

  vec_t vecs[7];
  int   edges;

  initial begin
    // Program: LDA 1E ; <instr> 1F ; HLT  with mem[1E]=a, mem[1F]=b
    vecs[0] = '{8'h5F, 8'h05, 8'h03, 8'h08, 8'h03};  // ADD
    vecs[1] = '{8'h5F, 8'hFF, 8'h02, 8'h01, 8'h02};  // ADD, carry dropped
    vecs[2] = '{8'h5F, 8'h80, 8'h80, 8'h00, 8'h80};  // ADD wraps to zero
    vecs[3] = '{8'h7F, 8'hF0, 8'h3C, 8'h30, 8'h3C};  // AND
    vecs[4] = '{8'h9F, 8'hF0, 8'h3C, 8'hCC, 8'h3C};  // XOR
    vecs[5] = '{8'hBF, 8'h11, 8'hA7, 8'hA7, 8'hA7};  // LDA
    vecs[6] = '{8'hDF, 8'h3C, 8'h77, 8'h3C, 8'h3C};  // STO

    // Reset mid-FETCH, then the reference program from a clean start
    clear_img();
    img[0] = 8'hBE; img[1] = 8'h5F; img[2] = 8'hDD; img[3] = 8'h00;
    img[5'h1E] = 8'h05; img[5'h1F] = 8'h03;
    wait_addr = 5'h01;
    wait_n    = 1000;
    do_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("stall_accum", accum, 8'h05);
    check("stall_rd", bus.mem_rd, 1'b1);
    check("stall_addr", bus.mem_addr, 5'h01);
    rst_ = 1'b0;
    #1;
    check("rst_pc", pc, 5'h00);
    check("rst_accum", accum, 8'h00);
    check("rst_halt", halt, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_load_ir", load_ir, 1'b0);
    wait_n = 0;
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check("rel_mem_rd", bus.mem_rd, 1'b1);
    check("rel_mem_addr", bus.mem_addr, 5'h00);
    run_to_halt(40, edges);
    check("prog_halt_cycle", edges, 11);
    check("prog_pc", pc, 5'h04);
    check("prog_accum", accum, 8'h08);
    check("prog_mem1d", mem[5'h1D], 8'h08);

    // Table of single-operation programs
    for (int v = 0; v < 7; v++) begin
      clear_img();
      img[0] = 8'hBE; img[1] = vecs[v].instr; img[2] = 8'h00;
      img[5'h1E] = vecs[v].a; img[5'h1F] = vecs[v].b;
      do_reset();
      run_to_halt(40, edges);
      check($sformatf("vec%0d_cycles", v), edges, 8);
      check($sformatf("vec%0d_accum", v), accum, vecs[v].exp_acc);
      check($sformatf("vec%0d_mem1f", v), mem[5'h1F], vecs[v].exp_m1f);
      check($sformatf("vec%0d_pc", v), pc, 5'h03);
    end

    // SKZ at pc=4 reached via JMP, with accum zero and non-zero
    for (int z = 0; z < 2; z++) begin
      clear_img();
      img[0] = 8'hBE; img[1] = 8'hE4; img[4] = 8'h20;
      img[5'h1E] = (z == 0) ? 8'h00 : 8'h01;
      do_reset();
      run_to_halt(40, edges);
      check($sformatf("skz%0d_cycles", z), edges, 9);
      check($sformatf("skz%0d_nfetch", z), fetch_log.size(), 4);
      check($sformatf("skz%0d_jmp_target", z), fetch_log[2], 5'h04);
      check($sformatf("skz%0d_next_fetch", z), fetch_log[3], (z == 0) ? 5'h06 : 5'h05);
      check($sformatf("skz%0d_pc", z), pc, (z == 0) ? 5'h07 : 5'h06);
    end

    // JMP 1F then SKZ with accum!=0: PC wraps to 0
    clear_img();
    img[0] = 8'hBE; img[1] = 8'hFF; img[5'h1F] = 8'h20; img[5'h1E] = 8'h07;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (fetch_log.size() >= 4) break;
    end
    check("wrap_nfetch", fetch_log.size() >= 4, 1'b1);
    check("wrap_jmp_target", fetch_log[2], 5'h1F);
    check("wrap_next_fetch", fetch_log[3], 5'h00);

    // LDA with three wait states in OPREAD
    clear_img();
    img[0] = 8'hBE; img[1] = 8'h00; img[5'h1E] = 8'h5A;
    wait_addr = 5'h1E;
    wait_n    = 3;
    do_reset();
    edges = -1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e >= 3 && e <= 5) begin
        check($sformatf("ws_rd_e%0d", e), bus.mem_rd, 1'b1);
        check($sformatf("ws_addr_e%0d", e), bus.mem_addr, 5'h1E);
        check($sformatf("ws_accum_e%0d", e), accum, 8'h00);
      end
      if (e == 6) check("ws_done_accum", accum, 8'h5A);
      if (e == 7) check("ws_not_halted", halt, 1'b0);
    end
    check("ws_halt_cycle", halt, 1'b1);
    wait_n = 0;

`ifdef RISC_CORE_PERF_EN
    // Five SKZ then HLT with CNT_W=2: counter saturates at 3
    clear_img();
    for (int i = 0; i < 5; i++) img[i] = 8'h20;
    do_reset();
    #1;
    check("cnt_reset", instr_count, 2'd0);
    run_to_halt(40, edges);
    check("cnt_halt_cycle", edges, 8);
    check("cnt_saturated", instr_count, 2'd3);
`endif

    check("rd_wr_exclusive", overlap_seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
